// File: rtl/feed_dispenser.sv
// Portion dispenser: runs the motor for POUR_CYCLES per portion, started by a count_enable
// rising edge or a periodic interval tick, and latches in LIMIT once MAX_PORTIONS are delivered.
module feed_dispenser #(
   parameter int unsigned POUR_CYCLES     = 50,
   parameter int unsigned INTERVAL_CYCLES = 1000,
   parameter int unsigned MAX_PORTIONS    = 15,
   parameter int unsigned CNT_W           = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       count_enable,
   input  logic       count_reset,
   input  logic       interval_enable,
   input  logic       interval_reset,
   output logic       motor_on,
   output logic       portion_done,
   output logic [3:0] portions,
   output logic       limit_reached,
   output logic       missed_tick
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_POUR  = 2'd1,
      ST_LIMIT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] POUR_LAST = CNT_W'(POUR_CYCLES - 1);
   localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(INTERVAL_CYCLES - 1);
   localparam logic [3:0]       MAX_P     = 4'(MAX_PORTIONS);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] pour_cnt_q, pour_cnt_d;
   logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
   logic [3:0]       portions_q, portions_d;
   logic             ce_d_q, ce_d_d;
   logic             motor_on_q, motor_on_d;
   logic             portion_done_q, portion_done_d;
   logic             limit_reached_q, limit_reached_d;
   logic             missed_tick_q, missed_tick_d;

   logic ce_rise;
   logic tick;

   assign ce_rise = count_enable & ~ce_d_q;
   // interval_reset suppresses the tick in the same cycle it clears the timer
   assign tick    = interval_enable & ~interval_reset & (int_cnt_q == INT_LAST);

   always_comb begin
      state_d         = state_q;
      pour_cnt_d      = pour_cnt_q;
      int_cnt_d       = int_cnt_q;
      portions_d      = portions_q;
      ce_d_d          = count_enable;
      portion_done_d  = 1'b0;
      missed_tick_d   = 1'b0;

      if (interval_reset) begin
         int_cnt_d = '0;
      end else if (interval_enable && (state_q != ST_LIMIT)) begin
         int_cnt_d = tick ? '0 : int_cnt_q + CNT_W'(1);
      end

      if (count_reset) begin
         state_d    = ST_IDLE;
         pour_cnt_d = '0;
         portions_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (portions_q >= MAX_P) begin
                  state_d = ST_LIMIT;
               end else if (ce_rise || tick) begin
                  state_d    = ST_POUR;
                  pour_cnt_d = '0;
               end
            end
            ST_POUR: begin
               // a tick arriving mid-pour is dropped, not queued
               missed_tick_d = tick;
               if (pour_cnt_q == POUR_LAST) begin
                  state_d        = ST_IDLE;
                  pour_cnt_d     = '0;
                  portion_done_d = 1'b1;
                  if (portions_q < MAX_P) begin
                     portions_d = portions_q + 4'd1;
                  end
               end else begin
                  pour_cnt_d = pour_cnt_q + CNT_W'(1);
               end
            end
            ST_LIMIT: begin
               state_d = ST_LIMIT;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      motor_on_d      = (state_d == ST_POUR);
      limit_reached_d = (state_d == ST_LIMIT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         pour_cnt_q      <= '0;
         int_cnt_q       <= '0;
         portions_q      <= '0;
         ce_d_q          <= 1'b0;
         motor_on_q      <= 1'b0;
         portion_done_q  <= 1'b0;
         limit_reached_q <= 1'b0;
         missed_tick_q   <= 1'b0;
      end else begin
         state_q         <= state_d;
         pour_cnt_q      <= pour_cnt_d;
         int_cnt_q       <= int_cnt_d;
         portions_q      <= portions_d;
         ce_d_q          <= ce_d_d;
         motor_on_q      <= motor_on_d;
         portion_done_q  <= portion_done_d;
         limit_reached_q <= limit_reached_d;
         missed_tick_q   <= missed_tick_d;
      end
   end

   assign motor_on      = motor_on_q;
   assign portion_done  = portion_done_q;
   assign portions      = portions_q;
   assign limit_reached = limit_reached_q;
   assign missed_tick   = missed_tick_q;

endmodule

// File: tb/tb_feed_dispenser.sv
// Scoreboard bench for feed_dispenser: stimulus queues expected output events with their edge
// numbers; a negedge monitor turns output changes into events and pops/compares them.
module tb_feed_dispenser;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       count_enable = 1'b0;
   logic       count_reset = 1'b0;
   logic       interval_enable = 1'b0;
   logic       interval_reset = 1'b0;
   logic       motor_on;
   logic       portion_done;
   logic [3:0] portions;
   logic       limit_reached;
   logic       missed_tick;

   feed_dispenser #(
      .POUR_CYCLES    (4),
      .INTERVAL_CYCLES(10),
      .MAX_PORTIONS   (3),
      .CNT_W          (16)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .count_enable   (count_enable),
      .count_reset    (count_reset),
      .interval_enable(interval_enable),
      .interval_reset (interval_reset),
      .motor_on       (motor_on),
      .portion_done   (portion_done),
      .portions       (portions),
      .limit_reached  (limit_reached),
      .missed_tick    (missed_tick)
   );

   always #5 clock = ~clock;

   localparam int K_MON  = 0;
   localparam int K_MOFF = 1;
   localparam int K_DONE = 2;
   localparam int K_MISS = 3;
   localparam int K_LOFF = 4;
   localparam int K_LON  = 5;

   typedef struct {
      int kind;
      int cyc;
      int val;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  edge_n = 0;
   bit  mon_en = 1'b0;
   bit  prev_motor = 1'b0;
   bit  prev_lim = 1'b0;

   always @(posedge clock) if (!reset) edge_n = edge_n + 1;

   function automatic string kname(input int k);
      case (k)
         K_MON:   return "motor_rise";
         K_MOFF:  return "motor_fall";
         K_DONE:  return "portion_done";
         K_MISS:  return "missed_tick";
         K_LOFF:  return "limit_fall";
         default: return "limit_rise";
      endcase
   endfunction

   task automatic push(input int kind, input int cyc, input int val);
      ev_t e;
      e.kind = kind;
      e.cyc  = cyc;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input int kind, input int val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event_%s: got unexpected event at edge %0d portions=%0d, required no event",
                  kname(kind), edge_n, val);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != edge_n || e.val != val) begin
            errors++;
            $display("FAIL event_%s: got %s at edge %0d portions=%0d, required %s at edge %0d portions=%0d",
                     kname(e.kind), kname(kind), edge_n, val, kname(e.kind), e.cyc, e.val);
         end
      end
   endtask

   task automatic chk(input string nm, input int got, input int expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, got, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Fixed event order within one edge; stimulus pushes in the same order.
   always @(negedge clock) begin
      if (mon_en) begin
         if (prev_motor && !motor_on) pop_check(K_MOFF, int'(portions));
         if (portion_done)            pop_check(K_DONE, int'(portions));
         if (missed_tick)             pop_check(K_MISS, int'(portions));
         if (prev_lim && !limit_reached) pop_check(K_LOFF, int'(portions));
         if (!prev_motor && motor_on) pop_check(K_MON, int'(portions));
         if (!prev_lim && limit_reached) pop_check(K_LON, int'(portions));
         prev_motor = motor_on;
         prev_lim   = limit_reached;
      end
   end

   initial begin
      int k;
      int n;
      int e;

      #12;
      chk("rst_motor_on", int'(motor_on), 0);
      chk("rst_portion_done", int'(portion_done), 0);
      chk("rst_portions", int'(portions), 0);
      chk("rst_limit_reached", int'(limit_reached), 0);
      chk("rst_missed_tick", int'(missed_tick), 0);
      @(negedge clock);
      reset  = 1'b0;
      mon_en = 1'b1;
      step(2);

      // manual portion, count_enable held high afterwards
      k = edge_n; n = k + 1;
      count_enable = 1'b1;
      push(K_MON, n, 0); push(K_MOFF, n + 4, 1); push(K_DONE, n + 4, 1);
      step(10);
      chk("s1_portions", int'(portions), 1);
      count_enable = 1'b0;
      step(2);

      // count_reset two cycles into a pour aborts it
      k = edge_n; n = k + 1;
      count_enable = 1'b1;
      push(K_MON, n, 1); push(K_MOFF, n + 2, 0);
      step(2);
      count_reset = 1'b1;
      step(1);
      count_reset  = 1'b0;
      count_enable = 1'b0;
      step(6);
      chk("s2_portions", int'(portions), 0);
      chk("s2_motor_on", int'(motor_on), 0);

      // automatic portions up to the limit
      k = edge_n; e = k + 1;
      interval_enable = 1'b1;
      push(K_MON, e + 9, 0);  push(K_MOFF, e + 13, 1); push(K_DONE, e + 13, 1);
      push(K_MON, e + 19, 1); push(K_MOFF, e + 23, 2); push(K_DONE, e + 23, 2);
      push(K_MON, e + 29, 2); push(K_MOFF, e + 33, 3); push(K_DONE, e + 33, 3);
      push(K_LON, e + 34, 3);
      step(35);
      interval_enable = 1'b0;
      chk("s3_portions", int'(portions), 3);
      chk("s3_limit_reached", int'(limit_reached), 1);

      // LIMIT ignores count_enable; both resets together leave it
      count_enable = 1'b1;
      step(3);
      count_enable = 1'b0;
      step(2);
      chk("s4_motor_in_limit", int'(motor_on), 0);
      k = edge_n;
      count_reset    = 1'b1;
      interval_reset = 1'b1;
      push(K_LOFF, k + 1, 0);
      step(1);
      count_reset    = 1'b0;
      interval_reset = 1'b0;
      step(2);
      chk("s4_portions", int'(portions), 0);
      chk("s4_limit_reached", int'(limit_reached), 0);

      // pour covering the tick: tick dropped with missed_tick, next tick 10 later
      k = edge_n; e = k + 1;
      interval_enable = 1'b1;
      push(K_MON, e + 7, 0);  push(K_MISS, e + 9, 0);
      push(K_MOFF, e + 11, 1); push(K_DONE, e + 11, 1);
      push(K_MON, e + 19, 1); push(K_MOFF, e + 23, 2); push(K_DONE, e + 23, 2);
      step(7);
      count_enable = 1'b1;
      step(2);
      count_enable = 1'b0;
      step(11);
      interval_enable = 1'b0;
      step(6);
      chk("s5_portions", int'(portions), 2);

      // ce_rise and tick on the same edge start one portion
      count_reset = 1'b1;
      step(1);
      count_reset = 1'b0;
      k = edge_n; e = k + 1;
      interval_enable = 1'b1;
      push(K_MON, e + 9, 0); push(K_MOFF, e + 13, 1); push(K_DONE, e + 13, 1);
      step(9);
      count_enable = 1'b1;
      step(2);
      count_enable = 1'b0;
      step(4);
      interval_enable = 1'b0;
      step(3);
      chk("s6_portions", int'(portions), 1);

      step(2);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/feed_dispenser.md
# feed_dispenser

Downstream execution stage of the feeder control path. It consumes the four level outputs of the option FSM: count_enable, count_reset, interval_enable and interval_reset. From these it drives the dispensing motor for a fixed number of cycles per portion. Portions are started manually on a rising edge of count_enable, or automatically every INTERVAL_CYCLES while interval_enable is held. The block counts delivered portions and stops at a configurable limit.

## Interface
- POUR_CYCLES, 50: motor-on duration of one portion, in clock cycles; must be ≥2.
- INTERVAL_CYCLES, 1000: period between automatic portions, in cycles; must be > POUR_CYCLES.
- MAX_PORTIONS, 15: portion limit; must fit in 4 bits and be ≥1.
- CNT_W, 16: width of the pour and interval counters; both cycle parameters must fit.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- count_enable  in  1  level; a rising edge requests one manual portion.
- count_reset  in  1  level, synchronous clear of the dispense path.
- interval_enable  in  1  level; enables automatic periodic portions.
- interval_reset  in  1  level, synchronous clear of the interval timer.
- motor_on  out  1  motor drive; high exactly while in POUR.
- portion_done  out  1  one-cycle pulse at the end of each portion.
- portions  out  4  count of completed portions.
- limit_reached  out  1  high while in LIMIT.
- missed_tick  out  1  one-cycle pulse when an interval tick occurs during POUR.

## Operation
- States: IDLE, POUR, LIMIT. All outputs are registered (Moore).
- Internal registers:
  - pour_cnt, int_cnt: CNT_W bits each.
  - portions: 4 bits.
  - ce_d: count_enable delayed one cycle.
  - ce_rise: count_enable & ~ce_d.
- Interval tick: interval_enable=1 and int_cnt==INTERVAL_CYCLES-1.
- int_cnt behaviour:
  - Increments each cycle while interval_enable=1 and state≠LIMIT.
  - Wraps to 0 on a tick.
  - Holds while interval_enable=0.
- Priority order, evaluated each cycle:
  1. count_reset=1: state→IDLE, pour_cnt=0, portions=0, all pulse outputs low.
  2. interval_reset=1: int_cnt=0; no tick this cycle.
  3. State logic below.
  - count_reset and interval_reset act independently. Both may be high together; each applies its own clear.
- IDLE:
  - If portions==MAX_PORTIONS → LIMIT.
  - Else if ce_rise or tick → POUR, pour_cnt=0.
  - ce_rise and tick in the same cycle start exactly one portion.
- POUR:
  - pour_cnt increments each cycle.
  - When pour_cnt==POUR_CYCLES-1: state→IDLE, portions+1, portion_done=1 for the next cycle.
  - ce_rise during POUR is ignored and not queued.
  - A tick during POUR is dropped and raises missed_tick for one cycle; int_cnt still wraps.
- LIMIT:
  - motor_on=0, limit_reached=1, int_cnt frozen.
  - Left only via count_reset or reset.
- count_reset during POUR aborts the portion: motor_on goes low on the next edge, with no portion_done and no increment.
- portions never exceeds MAX_PORTIONS and does not wrap.

## Timing
- Async reset values:
  - state=IDLE; motor_on=0, portion_done=0, portions=0, limit_reached=0, missed_tick=0.
  - pour_cnt=0, int_cnt=0, ce_d=0.
- Because ce_d resets to 0, count_enable already high at reset release is treated as a rising edge.
- Manual portion: count_enable first sampled high at edge N → motor_on high from N through N+POUR_CYCLES. The motor is on for exactly POUR_CYCLES cycles.
- At edge N+POUR_CYCLES: motor_on falls, portion_done rises for one cycle, and portions updates. These three changes occur on the same edge.
- Automatic portion: interval_enable first sampled high at edge E with int_cnt=0 → first motor_on rise at edge E+INTERVAL_CYCLES-1. Subsequent portions follow every INTERVAL_CYCLES cycles.
- The IDLE→LIMIT transition takes one cycle after the final portion_done.
- Minimum spacing of manual portions: POUR_CYCLES+1 cycles, because of the IDLE cycle between portions.

## Test plan
All scenarios use POUR_CYCLES=4, INTERVAL_CYCLES=10, MAX_PORTIONS=3, except where a scenario overrides a value.
- Reset, then count_enable 0→1 held high → motor_on high exactly 4 cycles, then one portion_done pulse, portions=1; no further portion while count_enable stays high.
- count_reset pulsed at cycle 2 of a pour → motor_on low next edge, no portion_done, portions=0, state IDLE.
- interval_enable held 35 cycles → motor_on rises at E+9, E+19 and E+29, and portions ends at 3.
- After portions reaches 3: limit_reached=1 next cycle, further ce_rise gives no motor_on, then count_reset → portions=0, limit_reached=0.
- INTERVAL_CYCLES=10 with ce_rise timed so that a pour covers the tick cycle → missed_tick pulse once, the tick portion is not dispensed, and the next tick occurs 10 cycles later.
- ce_rise and tick in the same IDLE cycle → a single 4-cycle pour, and portions increments by 1.
